// File: rtl/regfile_dual_read.sv
// Parametrised register file: one write port, two read ports with same-cycle write bypass.
// Read data is either registered (latency 1) or combinational, selected by REG_OUT.
module regfile_dual_read #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned SEL_W   = 4,
  parameter int unsigned REG_OUT = 1,
  parameter int unsigned ZERO_R0 = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [SEL_W-1:0] rd_sel_a,
  input  logic [SEL_W-1:0] rd_sel_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_valid
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [WIDTH-1:0] val_a_c;
  logic [WIDTH-1:0] val_b_c;

  // Write decode; out-of-range selects match no entry and are dropped
  always_comb begin
    regs_d = regs_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (wr_en && (wr_sel == SEL_W'(i)) && !((ZERO_R0 != 0) && (i == 0))) begin
        regs_d[i] = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Per-port read value with bypass; zeroed r0 and out-of-range selects never bypass
  always_comb begin
    val_a_c = '0;
    val_b_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rd_sel_a == SEL_W'(i)) begin
        val_a_c = (wr_en && (wr_sel == rd_sel_a)) ? wr_data : regs_q[i];
      end
      if (rd_sel_b == SEL_W'(i)) begin
        val_b_c = (wr_en && (wr_sel == rd_sel_b)) ? wr_data : regs_q[i];
      end
    end
    if (ZERO_R0 != 0) begin
      if (rd_sel_a == '0) val_a_c = '0;
      if (rd_sel_b == '0) val_b_c = '0;
    end
  end

  if (REG_OUT != 0) begin : g_reg_out
    logic [WIDTH-1:0] rd_data_a_q;
    logic [WIDTH-1:0] rd_data_a_d;
    logic [WIDTH-1:0] rd_data_b_q;
    logic [WIDTH-1:0] rd_data_b_d;
    logic             rd_valid_q;
    logic             rd_valid_d;

    // Data holds when no read is requested; valid tracks the request
    always_comb begin
      rd_data_a_d = rd_data_a_q;
      rd_data_b_d = rd_data_b_q;
      rd_valid_d  = rd_en;
      if (rd_en) begin
        rd_data_a_d = val_a_c;
        rd_data_b_d = val_b_c;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        rd_data_a_q <= '0;
        rd_data_b_q <= '0;
        rd_valid_q  <= 1'b0;
      end else begin
        rd_data_a_q <= rd_data_a_d;
        rd_data_b_q <= rd_data_b_d;
        rd_valid_q  <= rd_valid_d;
      end
    end

    assign rd_data_a = rd_data_a_q;
    assign rd_data_b = rd_data_b_q;
    assign rd_valid  = rd_valid_q;
  end else begin : g_comb_out
    assign rd_data_a = val_a_c;
    assign rd_data_b = val_b_c;
    assign rd_valid  = rd_en & ~reset;
  end

endmodule

// File: tb/tb_regfile_dual_read.sv
// Bench for regfile_dual_read: default registered instance plus a DEPTH=12, ZERO_R0=1,
// combinational-read instance, both sharing stimulus and checked against array models.
module tb_regfile_dual_read;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_sel;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [3:0]  rd_sel_a;
  logic [3:0]  rd_sel_b;
  logic [15:0] a1, b1, a2, b2;
  logic        v1, v2;

  int errors = 0;
  int checks = 0;

  logic [15:0] m1 [16];
  logic [15:0] m2 [16];
  logic [15:0] e1a, e1b;
  logic        e1v;

  always #5 clk = ~clk;

  regfile_dual_read #(.WIDTH(16), .DEPTH(16), .SEL_W(4), .REG_OUT(1), .ZERO_R0(0)) u_dut1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_en(rd_en), .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
    .rd_data_a(a1), .rd_data_b(b1), .rd_valid(v1)
  );

  regfile_dual_read #(.WIDTH(16), .DEPTH(12), .SEL_W(4), .REG_OUT(0), .ZERO_R0(1)) u_dut2 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_en(rd_en), .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
    .rd_data_a(a2), .rd_data_b(b2), .rd_valid(v2)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference read value for a register file of the given depth / r0 behaviour
  function automatic logic [15:0] ref_val(input int depth, input bit zero_r0,
                                          input logic [15:0] mem [16], input logic [3:0] sel);
    if (int'(sel) >= depth) return 16'h0000;
    if (zero_r0 && sel == 4'd0) return 16'h0000;
    if (wr_en && wr_sel == sel) return wr_data;
    return mem[sel];
  endfunction

  // One clock: drive, check comb instance, predict registered instance, advance, check it
  task automatic cycle(input logic rst, input logic we, input logic [3:0] ws,
                       input logic [15:0] wd, input logic re,
                       input logic [3:0] sa, input logic [3:0] sb);
    @(negedge clk);
    reset = rst; wr_en = we; wr_sel = ws; wr_data = wd;
    rd_en = re; rd_sel_a = sa; rd_sel_b = sb;
    #1;
    chk("comb_valid", {15'd0, v2}, {15'd0, re & ~rst});
    if (!rst) begin
      chk("comb_a", a2, ref_val(12, 1'b1, m2, sa));
      chk("comb_b", b2, ref_val(12, 1'b1, m2, sb));
    end
    if (rst) begin
      e1a = 16'h0; e1b = 16'h0; e1v = 1'b0;
    end else begin
      e1v = re;
      if (re) begin
        e1a = ref_val(16, 1'b0, m1, sa);
        e1b = ref_val(16, 1'b0, m1, sb);
      end
    end
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m1[i] = 16'h0;
        m2[i] = 16'h0;
      end
    end else if (we) begin
      m1[ws] = wd;
      if (int'(ws) < 12 && ws != 4'd0) m2[ws] = wd;
    end
    @(posedge clk);
    #1;
    chk("reg_a", a1, e1a);
    chk("reg_b", b1, e1b);
    chk("reg_valid", {15'd0, v1}, {15'd0, e1v});
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_sel = '0; wr_data = '0;
    rd_en = 1'b0; rd_sel_a = '0; rd_sel_b = '0;
    for (int i = 0; i < 16; i++) begin
      m1[i] = 16'h0;
      m2[i] = 16'h0;
    end
    e1a = 16'h0; e1b = 16'h0; e1v = 1'b0;

    cycle(1, 0, 4'd0, 16'h0, 0, 4'd0, 4'd0);
    cycle(1, 1, 4'd2, 16'hAAAA, 1, 4'd2, 4'd2);
    // Read after reset returns zeros
    cycle(0, 0, 4'd0, 16'h0, 1, 4'd3, 4'd15);
    // Write then read
    cycle(0, 1, 4'd5, 16'hBEEF, 0, 4'd0, 4'd0);
    cycle(0, 0, 4'd0, 16'h0, 1, 4'd5, 4'd4);
    // Bypass on both ports
    cycle(0, 1, 4'd7, 16'h1234, 1, 4'd7, 4'd7);
    cycle(0, 0, 4'd0, 16'h0, 1, 4'd7, 4'd5);
    // r0 write: kept in DUT1, discarded in DUT2 (bypass suppressed too)
    cycle(0, 1, 4'd0, 16'hFFFF, 1, 4'd0, 4'd0);
    cycle(0, 0, 4'd0, 16'h0, 1, 4'd0, 4'd1);
    // Out-of-range for DEPTH=12
    cycle(0, 1, 4'd13, 16'h5A5A, 1, 4'd13, 4'd11);
    cycle(0, 0, 4'd0, 16'h0, 1, 4'd13, 4'd12);
    for (int i = 1; i < 12; i++) cycle(0, 0, 4'd0, 16'h0, 1, 4'(i), 4'(i));
    // Read pulse then hold
    cycle(0, 0, 4'd0, 16'h0, 1, 4'd5, 4'd7);
    for (int i = 0; i < 3; i++) cycle(0, 1, 4'd9, 16'(16'h0100 + i), 0, 4'd9, 4'd1);
    // Reset with read request
    cycle(1, 1, 4'd3, 16'h7777, 1, 4'd5, 4'd7);
    cycle(0, 0, 4'd0, 16'h0, 1, 4'd5, 4'd7);
    // Fill and read symmetric pairs
    for (int i = 0; i < 16; i++) cycle(0, 1, 4'(i), 16'(i * 16'h1111), 0, 4'd0, 4'd0);
    for (int i = 0; i < 16; i++) cycle(0, 0, 4'd0, 16'h0, 1, 4'(i), 4'(15 - i));
    // Random traffic
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 31) == 0), 1'($urandom), 4'($urandom), 16'($urandom),
            1'($urandom), 4'($urandom), 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
